// File: rtl/ats21_pkg.sv
// Shared types for the ATS21 command scheduler: opcodes, command layout,
// response encoding and the lane-conflict rule.
package ats21_pkg;

  localparam int unsigned CMD_W  = 32;
  localparam int unsigned LANE_W = 16;

  typedef enum logic [2:0] {
    OP_NOP     = 3'b000,
    OP_SET_CLK = 3'b001,
    OP_EN_CLK  = 3'b010,
    OP_MODE    = 3'b011,
    OP_SET_ALM = 3'b101,
    OP_SET_TMR = 3'b110,
    OP_EN_ALM  = 3'b111
  } ats21_op_e;

  typedef struct packed {
    ats21_op_e   op;
    logic [28:0] arg;
  } ats21_cmd_t;

  typedef enum logic {
    RSP_NACK = 1'b0,
    RSP_ACK  = 1'b1
  } ats21_rsp_e;

  // True when the two commands would make the ATS21 NACK if issued together.
  function automatic logic ats21_conflict(input ats21_cmd_t a, input ats21_cmd_t b);
    logic id4_eq;
    logic id5_eq;
    logic a_at;
    logic b_at;
    id4_eq = (a.arg[28:25] == b.arg[28:25]);
    id5_eq = (a.arg[28:24] == b.arg[28:24]);
    a_at   = (a.op == OP_SET_ALM) || (a.op == OP_SET_TMR);
    b_at   = (b.op == OP_SET_ALM) || (b.op == OP_SET_TMR);
    ats21_conflict = 1'b0;
    if ((a.op == b.op) && ((a.op == OP_SET_CLK) || (a.op == OP_EN_CLK))) begin
      ats21_conflict = id4_eq;
    end else if ((a.op == b.op) &&
                 ((a.op == OP_SET_ALM) || (a.op == OP_SET_TMR) || (a.op == OP_EN_ALM))) begin
      ats21_conflict = id5_eq;
    end else if (a_at && b_at) begin
      ats21_conflict = id5_eq;
    end else if ((a.op == OP_MODE) && (b.op == OP_MODE)) begin
      ats21_conflict = 1'b1;
    end
  endfunction

endpackage

// File: rtl/ats21_cmd_fifo.sv
// Per-client command FIFO; pointers wrap modulo DEPTH, count is registered.
module ats21_cmd_fifo
  import ats21_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  ats21_cmd_t               push_cmd,
  input  logic                     pop,
  output ats21_cmd_t               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  ats21_cmd_t        mem_q [DEPTH];
  ats21_cmd_t        mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_cmd;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ats21_cmd_sched.sv
// Two-client front-end for the ATS21 timer: serialises 32-bit commands onto
// fixed lanes, avoids conflicting co-issue with round-robin, routes ACK/NACK.
module ats21_cmd_sched
  import ats21_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned STAT_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_valid,
  input  logic [CMD_W-1:0]  a_cmd,
  output logic              a_ready,
  output logic              a_rsp_valid,
  output logic              a_rsp_ack,
  input  logic              b_valid,
  input  logic [CMD_W-1:0]  b_cmd,
  output logic              b_ready,
  output logic              b_rsp_valid,
  output logic              b_rsp_ack,
  output logic              req,
  output logic [LANE_W-1:0] ctrlA,
  output logic [LANE_W-1:0] ctrlB,
  input  logic [1:0]        stat
);

  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned WCNT_W = (STAT_LAT > 1) ? $clog2(STAT_LAT) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BEAT0,
    ST_BEAT1,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e            state_q, state_d;
  logic              iss_a_q, iss_a_d;
  logic              iss_b_q, iss_b_d;
  logic              rr_q, rr_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [1:0]        stat_q, stat_d;
  logic              req_q, req_d;
  logic [LANE_W-1:0] ctrl_a_q, ctrl_a_d;
  logic [LANE_W-1:0] ctrl_b_q, ctrl_b_d;
  logic              a_rsp_valid_q, a_rsp_valid_d;
  logic              a_rsp_ack_q, a_rsp_ack_d;
  logic              b_rsp_valid_q, b_rsp_valid_d;
  logic              b_rsp_ack_q, b_rsp_ack_d;

  ats21_cmd_t        a_head, b_head;
  logic              a_full, b_full;
  logic              a_empty, b_empty;
  logic [CNT_W-1:0]  a_count, b_count;
  logic              pop_a, pop_b;
  logic              nop_a, nop_b;
  logic              cand_a, cand_b;
  logic              pair_conflict;

  assign a_ready = (a_count != CNT_W'(DEPTH));
  assign b_ready = (b_count != CNT_W'(DEPTH));

  ats21_cmd_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (a_valid && !a_full),
    .push_cmd (ats21_cmd_t'(a_cmd)),
    .pop      (pop_a),
    .head     (a_head),
    .full     (a_full),
    .empty    (a_empty),
    .count    (a_count)
  );

  ats21_cmd_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (b_valid && !b_full),
    .push_cmd (ats21_cmd_t'(b_cmd)),
    .pop      (pop_b),
    .head     (b_head),
    .full     (b_full),
    .empty    (b_empty),
    .count    (b_count)
  );

  assign nop_a         = !a_empty && (a_head.op == OP_NOP);
  assign nop_b         = !b_empty && (b_head.op == OP_NOP);
  assign cand_a        = !a_empty && !nop_a;
  assign cand_b        = !b_empty && !nop_b;
  assign pair_conflict = cand_a && cand_b && ats21_conflict(a_head, b_head);

  // Next-state and registered-output logic; outputs take effect the cycle after.
  always_comb begin
    state_d       = state_q;
    iss_a_d       = iss_a_q;
    iss_b_d       = iss_b_q;
    rr_d          = rr_q;
    wcnt_d        = wcnt_q;
    stat_d        = stat_q;
    req_d         = 1'b0;
    ctrl_a_d      = '0;
    ctrl_b_d      = '0;
    a_rsp_valid_d = 1'b0;
    a_rsp_ack_d   = RSP_NACK;
    b_rsp_valid_d = 1'b0;
    b_rsp_ack_d   = RSP_NACK;
    pop_a         = 1'b0;
    pop_b         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Nops never reach the timer; they complete here with a NACK.
        if (nop_a) begin
          pop_a         = 1'b1;
          a_rsp_valid_d = 1'b1;
        end
        if (nop_b) begin
          pop_b         = 1'b1;
          b_rsp_valid_d = 1'b1;
        end
        if (cand_a || cand_b) begin
          iss_a_d = cand_a;
          iss_b_d = cand_b;
          if (pair_conflict) begin
            iss_a_d = !rr_q;
            iss_b_d = rr_q;
            rr_d    = !rr_q;
          end
          state_d  = ST_BEAT0;
          req_d    = 1'b1;
          ctrl_a_d = iss_a_d ? a_head[31:16] : '0;
          ctrl_b_d = iss_b_d ? b_head[31:16] : '0;
        end
      end
      ST_BEAT0: begin
        state_d  = ST_BEAT1;
        ctrl_a_d = iss_a_q ? a_head[15:0] : '0;
        ctrl_b_d = iss_b_q ? b_head[15:0] : '0;
      end
      ST_BEAT1: begin
        state_d = ST_WAIT;
        wcnt_d  = '0;
      end
      ST_WAIT: begin
        if (wcnt_q == WCNT_W'(STAT_LAT - 1)) begin
          stat_d  = stat;
          state_d = ST_RESP;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      ST_RESP: begin
        pop_a         = iss_a_q;
        pop_b         = iss_b_q;
        a_rsp_valid_d = iss_a_q;
        a_rsp_ack_d   = iss_a_q && stat_q[0];
        b_rsp_valid_d = iss_b_q;
        b_rsp_ack_d   = iss_b_q && stat_q[1];
        iss_a_d       = 1'b0;
        iss_b_d       = 1'b0;
        state_d       = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      iss_a_q       <= 1'b0;
      iss_b_q       <= 1'b0;
      rr_q          <= 1'b0;
      wcnt_q        <= '0;
      stat_q        <= '0;
      req_q         <= 1'b0;
      ctrl_a_q      <= '0;
      ctrl_b_q      <= '0;
      a_rsp_valid_q <= 1'b0;
      a_rsp_ack_q   <= 1'b0;
      b_rsp_valid_q <= 1'b0;
      b_rsp_ack_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      iss_a_q       <= iss_a_d;
      iss_b_q       <= iss_b_d;
      rr_q          <= rr_d;
      wcnt_q        <= wcnt_d;
      stat_q        <= stat_d;
      req_q         <= req_d;
      ctrl_a_q      <= ctrl_a_d;
      ctrl_b_q      <= ctrl_b_d;
      a_rsp_valid_q <= a_rsp_valid_d;
      a_rsp_ack_q   <= a_rsp_ack_d;
      b_rsp_valid_q <= b_rsp_valid_d;
      b_rsp_ack_q   <= b_rsp_ack_d;
    end
  end

  assign req         = req_q;
  assign ctrlA       = ctrl_a_q;
  assign ctrlB       = ctrl_b_q;
  assign a_rsp_valid = a_rsp_valid_q;
  assign a_rsp_ack   = a_rsp_ack_q;
  assign b_rsp_valid = b_rsp_valid_q;
  assign b_rsp_ack   = b_rsp_ack_q;

endmodule

// File: tb/tb_ats21_cmd_sched.sv
// Bench for ats21_cmd_sched: directed scenarios plus random traffic, every
// cycle compared against a transaction-timeline reference model.
module tb_ats21_cmd_sched;

  localparam int DEPTH    = 4;
  localparam int STAT_LAT = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [31:0] a_cmd = '0, b_cmd = '0;
  logic [1:0]  stat = '0;
  logic        a_ready, b_ready, a_rsp_valid, b_rsp_valid, a_rsp_ack, b_rsp_ack;
  logic        req;
  logic [15:0] ctrlA, ctrlB;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  ats21_cmd_sched #(.DEPTH(DEPTH), .STAT_LAT(STAT_LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_valid(a_valid), .a_cmd(a_cmd), .a_ready(a_ready),
    .a_rsp_valid(a_rsp_valid), .a_rsp_ack(a_rsp_ack),
    .b_valid(b_valid), .b_cmd(b_cmd), .b_ready(b_ready),
    .b_rsp_valid(b_rsp_valid), .b_rsp_ack(b_rsp_ack),
    .req(req), .ctrlA(ctrlA), .ctrlB(ctrlB), .stat(stat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference conflict rule, grouped by resource rather than by opcode case.
  function automatic bit m_conflict(input logic [31:0] x, input logic [31:0] y);
    int ox, oy;
    ox = int'(x[31:29]);
    oy = int'(y[31:29]);
    if (ox == 3 && oy == 3) return 1'b1;
    if (ox == oy && (ox == 1 || ox == 2)) return x[28:25] == y[28:25];
    if (ox >= 5 && oy >= 5 && (ox == oy || (ox != 7 && oy != 7)))
      return x[28:24] == y[28:24];
    return 1'b0;
  endfunction

  // Model: each transaction is a timeline of edges counted from its issue edge.
  logic [31:0] qa[$], qb[$];
  bit          busy = 0, rr = 0, ia = 0, ib = 0;
  int          t = 0;
  logic [31:0] ca = '0, cb = '0;
  logic [1:0]  cap = '0;
  bit          pa, pb, na, nb, cda, cdb;
  bit          acc_a = 0, acc_b = 0;
  logic        e_req = 0, e_arv = 0, e_ara = 0, e_brv = 0, e_bra = 0;
  logic        e_ardy = 1, e_brdy = 1;
  logic [15:0] e_ca = '0, e_cb = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      qa.delete(); qb.delete();
      busy = 0; rr = 0; t = 0; ia = 0; ib = 0;
      e_req = 0; e_ca = '0; e_cb = '0;
      e_arv = 0; e_ara = 0; e_brv = 0; e_bra = 0;
      e_ardy = 1; e_brdy = 1; acc_a = 0; acc_b = 0;
    end else begin
      pa = a_valid && (qa.size() < DEPTH);
      pb = b_valid && (qb.size() < DEPTH);
      e_req = 0; e_ca = '0; e_cb = '0;
      e_arv = 0; e_ara = 0; e_brv = 0; e_bra = 0;
      if (busy) begin
        t++;
        if (t == 1) begin
          e_ca = ia ? ca[15:0] : 16'h0;
          e_cb = ib ? cb[15:0] : 16'h0;
        end
        if (t == 2 + STAT_LAT) cap = stat;
        if (t == 3 + STAT_LAT) begin
          if (ia) begin void'(qa.pop_front()); e_arv = 1; e_ara = cap[0]; end
          if (ib) begin void'(qb.pop_front()); e_brv = 1; e_bra = cap[1]; end
          busy = 0;
        end
      end else begin
        na  = (qa.size() > 0) && (qa[0][31:29] == 3'b000);
        nb  = (qb.size() > 0) && (qb[0][31:29] == 3'b000);
        cda = (qa.size() > 0) && !na;
        cdb = (qb.size() > 0) && !nb;
        ia = cda; ib = cdb;
        if (cda && cdb && m_conflict(qa[0], qb[0])) begin
          if (!rr) begin ib = 0; rr = 1; end
          else     begin ia = 0; rr = 0; end
        end
        if (ia || ib) begin
          busy = 1; t = 0;
          ca = ia ? qa[0] : 32'h0;
          cb = ib ? qb[0] : 32'h0;
          e_req = 1;
          e_ca = ca[31:16];
          e_cb = cb[31:16];
        end
        if (na) begin void'(qa.pop_front()); e_arv = 1; e_ara = 0; end
        if (nb) begin void'(qb.pop_front()); e_brv = 1; e_bra = 0; end
      end
      if (pa) qa.push_back(a_cmd);
      if (pb) qb.push_back(b_cmd);
      acc_a = pa; acc_b = pb;
      e_ardy = qa.size() < DEPTH;
      e_brdy = qb.size() < DEPTH;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req", 32'(req), 32'(e_req));
      chk("ctrlA", 32'(ctrlA), 32'(e_ca));
      chk("ctrlB", 32'(ctrlB), 32'(e_cb));
      chk("a_ready", 32'(a_ready), 32'(e_ardy));
      chk("b_ready", 32'(b_ready), 32'(e_brdy));
      chk("a_rsp_valid", 32'(a_rsp_valid), 32'(e_arv));
      chk("b_rsp_valid", 32'(b_rsp_valid), 32'(e_brv));
      if (e_arv) chk("a_rsp_ack", 32'(a_rsp_ack), 32'(e_ara));
      if (e_brv) chk("b_rsp_ack", 32'(b_rsp_ack), 32'(e_bra));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_ab(input bit da, input logic [31:0] cmda,
                         input bit db, input logic [31:0] cmdb);
    int n;
    bit pend_a, pend_b;
    pend_a = da; pend_b = db; n = 0;
    a_valid = pend_a; a_cmd = cmda;
    b_valid = pend_b; b_cmd = cmdb;
    while ((pend_a || pend_b) && n < 200) begin
      @(negedge clk); n++;
      if (acc_a) pend_a = 0;
      if (acc_b) pend_b = 0;
      a_valid = pend_a; b_valid = pend_b;
    end
    if (pend_a) chk("push_a_timeout", 32'(pend_a), 32'd0);
    if (pend_b) chk("push_b_timeout", 32'(pend_b), 32'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0 || busy) && n < 1000) begin
      tick(); n++;
    end
    tick(2);
  endtask

  function automatic logic [31:0] rnd_cmd();
    logic [31:0] c;
    c = $urandom;
    c[31:29] = 3'($urandom_range(0, 7));
    c[28:24] = 5'($urandom_range(0, 3));
    return c;
  endfunction

  initial begin
    int n;
    tick(3);
    chk_en = 1;
    reset_n = 1'b1;
    tick(2);

    // Reset mid-BEAT1 with two entries per client.
    push_ab(1, 32'h2A40_0010, 1, 32'h4A40_0011);
    push_ab(1, 32'h2C00_0001, 1, 32'h4C00_0002);
    n = 0;
    while (!req && n < 20) begin tick(); n++; end
    chk("t1_req_seen", 32'(req), 32'd1);
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk("t1_rst_req", 32'(req), 32'd0);
    chk("t1_rst_ctrlA", 32'(ctrlA), 32'd0);
    chk("t1_rst_ctrlB", 32'(ctrlB), 32'd0);
    chk("t1_rst_ready", {30'd0, a_ready, b_ready}, 32'd3);
    chk("t1_rst_rsp", {30'd0, a_rsp_valid, b_rsp_valid}, 32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(5);

    // Single issue with ACK; latency from push edge.
    stat = 2'b01;
    push_ab(1, 32'h2A40_0010, 0, 32'h0);
    n = 0;
    while (!a_rsp_valid && n < 20) begin tick(); n++; end
    chk("t2_latency", 32'(n), 32'(4 + STAT_LAT));
    chk("t2_ack", 32'(a_rsp_ack), 32'd1);
    wait_idle();

    // Non-conflicting pair, then conflicting set-timer round-robin.
    stat = 2'b11;
    push_ab(1, 32'hA300_0005, 1, 32'hA400_0007);
    wait_idle();
    push_ab(1, 32'hC700_0001, 1, 32'hC700_0002);
    push_ab(1, 32'hC700_0003, 1, 32'hC700_0004);
    wait_idle();

    // Backpressure: five back-to-back pushes into A.
    stat = 2'b01;
    for (int i = 0; i < 5; i++) push_ab(1, 32'h2000_0100 + 32'(i), 0, 32'h0);
    wait_idle();

    // Nop completes with NACK and no req; lane-B NACK from stat.
    push_ab(1, 32'h0000_0000, 0, 32'h0);
    n = 0;
    while (!a_rsp_valid && n < 20) begin tick(); n++; end
    chk("t6_nop_latency", 32'(n), 32'd1);
    chk("t6_nop_ack", 32'(a_rsp_ack), 32'd0);
    stat = 2'b01;
    push_ab(0, 32'h0, 1, 32'h2A40_0010);
    wait_idle();

    // Random traffic with random status.
    for (int i = 0; i < 1500; i++) begin
      a_valid = 1'($urandom_range(0, 1));
      b_valid = 1'($urandom_range(0, 1));
      a_cmd = rnd_cmd();
      b_cmd = rnd_cmd();
      stat = 2'($urandom_range(0, 3));
      tick();
    end
    a_valid = 0; b_valid = 0;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
